instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
IF stage of the pipelined RV32I core. Owns the PC, issues word fetches to instruction memory over a req/gnt request channel with in-order, variable-latency responses, and buffers returned instructions in a small reservation queue. Presents {instr, pc} to the ID stage with a valid/ready handshake; ID feeds the instruction to the immediate generator and decoder. Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset.
FIFO_DEPTH, 4, reservation-queue entries, power of two, >= 2; bounds outstanding plus buffered fetches.

Ports:
clk_i  in  1  clock, all state on rising edge.
rst_i  in  1  synchronous, active-high reset.
imem_req_o  out  1  fetch request valid.
imem_addr_o  out  32  fetch address, word aligned.
imem_gnt_i  in  1  request accepted this cycle; counts only when imem_req_o=1.
imem_rvalid_i  in  1  response valid; responses return in grant order.
imem_rdata_i  in  32  instruction word for the oldest outstanding grant.
redirect_i  in  1  flush and redirect, from EX branch resolution.
redirect_pc_i  in  32  redirect target.
id_valid_o  out  1  head instruction valid for ID.
id_instr_o  out  32  head instruction.
id_pc_o  out  32  PC of head instruction.
id_ready_i  in  1  ID accepts; transfer when id_valid_o & id_ready_i.

Behaviour:
- Reset (rst_i=1 at an edge): pc_q=RESET_PC, queue empty, kill_cnt=0; while rst_i=1: imem_req_o=0, id_valid_o=0, id_instr_o=32'h0000_0013 (NOP), id_pc_o=0. Reset mid-operation discards everything; instruction memory is reset in the same cycle.
- Queue entry = {pc, instr, filled}. Grant allocates the tail with pc=pc_q, filled=0; rvalid fills the oldest unfilled entry; head pops on ID handshake.
- Issue: imem_req_o = !rst_i & !redirect_i & (occupancy + kill_cnt < FIFO_DEPTH), all from registered state; a pop frees credit the following cycle. imem_addr_o = pc_q. On req & gnt: pc_q += 4 (wraps at 2^32), allocate entry.
- Ungranted request: addr and req held stable until gnt unless redirect_i withdraws it.
- Response: rvalid with kill_cnt>0 -> data dropped, kill_cnt-1. Otherwise fills oldest unfilled entry. rvalid with kill_cnt=0 and no unfilled entry is a protocol error: ignored, simulation assertion fires.
- Output: id_valid_o = head.filled; id_instr_o/id_pc_o = head fields (NOP/0 when empty). All outputs register-driven. Minimum latency: grant cycle N, rvalid N+1, id_valid_o N+2. With 1-cycle memory and id_ready_i=1, sustained 1 instr/cycle at FIFO_DEPTH>=3.
- Stall: id_ready_i=0 -> head outputs held stable; issue stops once credit is exhausted.
- Redirect (redirect_i=1 at an edge): queue cleared; kill_cnt <= kill_cnt + unfilled_count - (imem_rvalid_i ? 1 : 0); pc_q <= {redirect_pc_i[31:2],2'b00}; imem_req_o=0 that cycle, so no grant is possible. id_valid_o=0 next cycle. A handshake in the redirect cycle still completes for ID's side; the entry is discarded regardless.
- Redirect takes priority over pop, fill and issue in the same cycle. rst_i takes priority over redirect.
- kill_cnt width clog2(FIFO_DEPTH)+1; never exceeds FIFO_DEPTH.

Decomposition:
- fetch_pkg: NOP_INSTR = 32'h0000_0013, fetch_entry_t {pc[31:0], instr[31:0], filled}, default RESET_PC constant.
- Sub-module fetch_queue: reservation FIFO with alloc (tail), fill (oldest unfilled pointer), pop (head) and flush; it exports occupancy and unfilled_count. The top holds pc_q, kill_cnt, issue logic and redirect handling.

Test Plan:
- Reset release, 1-cycle memory, gnt=1, id_ready_i=1 -> addresses 0,4,8,...; first id_valid_o 2 cycles after first grant with pc 0; then one instr per cycle in pc order.
- id_ready_i=0 for 8 cycles -> exactly 4 grants, then imem_req_o=0; id_pc_o=0 and id_instr_o stable; resume -> pcs 0,4,8,12,16 with no gaps or duplicates.
- 3-cycle memory latency, 2 outstanding, redirect to 0x100 -> next 2 rvalids dropped, kill_cnt returns to 0; next id_pc_o=0x100 with the 0x100 data.
- redirect_i and imem_rvalid_i in the same cycle with 2 unfilled entries -> kill_cnt=1; exactly one later response dropped.
- redirect_pc_i=0x0000_0102 -> imem_addr_o=0x100, id_pc_o=0x100.
- gnt withheld for 3 cycles -> addr stable throughout; then rst_i mid-stream with 2 outstanding -> id_valid_o=0, id_instr_o=NOP, the next fetch addr is RESET_PC.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit.
//   NOP_INSTR        : encoding of addi x0,x0,0, shown to ID when nothing is valid
//   DEFAULT_RESET_PC : default first fetch address after reset
//   fetch_entry_t    : one reservation-queue slot {pc, instr, filled}
package instr_fetch_unit_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        filled;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle between the fetch unit, instruction memory, EX and ID.
//   imem_req_o/imem_addr_o : fetch request and word address (fetch unit drives)
//   imem_gnt_i             : request accepted this cycle
//   imem_rvalid_i/rdata_i  : in-order responses, one per earlier grant
//   redirect_i/redirect_pc_i : flush and restart fetch at a new target
//   id_valid_o/id_instr_o/id_pc_o/id_ready_i : instruction hand-off to ID
//
// Handshake semantics: an ID transfer happens in exactly the cycle where
// id_valid_o & id_ready_i are both high; while id_valid_o=1 and id_ready_i=0
// the id_* outputs hold stable. A fetch is accepted in exactly the cycle where
// imem_req_o & imem_gnt_i are both high; an ungranted request keeps its
// address stable unless a redirect withdraws it.
interface instr_fetch_unit_if;

  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        id_valid_o;
  logic [31:0] id_instr_o;
  logic [31:0] id_pc_o;
  logic        id_ready_i;

  modport master (
    output imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
           id_ready_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, id_valid_o, id_instr_o, id_pc_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, redirect_i, redirect_pc_i,
           id_ready_i
  );

endinterface

// File: rtl/instr_fetch_unit_queue.sv
// Reservation FIFO for fetched instructions.
//   alloc      : reserve tail slot for a granted fetch (pc known, instr pending)
//   fill       : write returned instruction into the oldest unfilled slot
//   pop        : retire the head slot
//   flush      : drop everything (redirect)
//   head_*     : head slot contents; NOP/0 when empty
//   occupancy  : allocated slots, unfilled : allocated slots still awaiting data
module instr_fetch_unit_queue
  import instr_fetch_unit_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     alloc,
  input  logic [31:0]              alloc_pc,
  input  logic                     fill,
  input  logic [31:0]              fill_instr,
  input  logic                     pop,
  output logic                     head_valid,
  output logic [31:0]              head_instr,
  output logic [31:0]              head_pc,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [$clog2(DEPTH):0]   unfilled
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] head_q, tail_q, fill_q;
  logic [CW-1:0] cnt_q, ucnt_q;

  // Pointers and counters; flush simply rewinds everything.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head_q <= '0;
      tail_q <= '0;
      fill_q <= '0;
      cnt_q  <= '0;
      ucnt_q <= '0;
    end else begin
      if (alloc) tail_q <= tail_q + AW'(1);
      if (fill)  fill_q <= fill_q + AW'(1);
      if (pop)   head_q <= head_q + AW'(1);
      cnt_q  <= cnt_q  + CW'(alloc) - CW'(pop);
      ucnt_q <= ucnt_q + CW'(alloc) - CW'(fill);
    end
  end

  // Slot storage. The caller never allocates into a full queue and only
  // fills when an unfilled slot exists, so tail and fill never collide.
  always_ff @(posedge clk) begin
    if (!rst && !flush) begin
      if (alloc) begin
        mem[tail_q] <= '{pc: alloc_pc, instr: NOP_INSTR, filled: 1'b0};
      end
      if (fill) begin
        mem[fill_q].instr  <= fill_instr;
        mem[fill_q].filled <= 1'b1;
      end
    end
  end

  assign head_valid = (cnt_q != '0) && mem[head_q].filled;
  assign head_instr = (cnt_q != '0) ? mem[head_q].instr : NOP_INSTR;
  assign head_pc    = (cnt_q != '0) ? mem[head_q].pc    : 32'h0;
  assign occupancy  = cnt_q;
  assign unfilled   = ucnt_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: owns the PC, issues word fetches over req/gnt, buffers in-order
// responses in a reservation queue and presents {instr, pc} to ID.
//   clk_i, rst_i : clock, synchronous active-high reset
//   bus (master) : imem request/response, redirect from EX, ID hand-off
// Responses for fetches that were in flight at a redirect are counted in
// kill_cnt and dropped as they arrive.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  instr_fetch_unit_if.master  bus
);

  localparam int unsigned KW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [KW:0] DEPTH_W = FIFO_DEPTH[KW:0];

  logic [31:0]   pc_q;
  logic [KW-1:0] kill_cnt;
  logic [KW-1:0] occupancy, unfilled;
  logic          head_valid;
  logic [31:0]   head_instr, head_pc;
  logic [KW:0]   credit_used, kill_sum, kill_redirect;
  logic          req, grant, fill, drop, pop;

  // Every granted fetch either sits in the queue or is still owed a response
  // that will be killed, so both count against the queue depth.
  assign credit_used = {1'b0, occupancy} + {1'b0, kill_cnt};
  assign req   = !rst_i && !bus.redirect_i && (credit_used < DEPTH_W);
  assign grant = req && bus.imem_gnt_i;
  assign drop  = bus.imem_rvalid_i && (kill_cnt != '0);
  assign fill  = !bus.redirect_i && bus.imem_rvalid_i && (kill_cnt == '0) && (unfilled != '0);
  assign pop   = !rst_i && head_valid && bus.id_ready_i;

  // At a redirect every unfilled slot becomes a response to kill; a response
  // arriving in the same cycle settles one of the outstanding ones (either a
  // pending kill or the slot it would have filled).
  assign kill_sum      = {1'b0, kill_cnt} + {1'b0, unfilled};
  assign kill_redirect = kill_sum - (KW+1)'(bus.imem_rvalid_i && (kill_sum != '0));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q     <= RESET_PC;
      kill_cnt <= '0;
    end else if (bus.redirect_i) begin
      pc_q     <= {bus.redirect_pc_i[31:2], 2'b00};
      kill_cnt <= kill_redirect[KW-1:0];
    end else begin
      if (grant) pc_q <= pc_q + 32'd4;
      if (drop)  kill_cnt <= kill_cnt - KW'(1);
    end
  end

  instr_fetch_unit_queue #(.DEPTH(FIFO_DEPTH)) u_queue (
    .clk        (clk_i),
    .rst        (rst_i),
    .flush      (bus.redirect_i),
    .alloc      (grant),
    .alloc_pc   (pc_q),
    .fill       (fill),
    .fill_instr (bus.imem_rdata_i),
    .pop        (pop),
    .head_valid (head_valid),
    .head_instr (head_instr),
    .head_pc    (head_pc),
    .occupancy  (occupancy),
    .unfilled   (unfilled)
  );

  assign bus.imem_req_o  = req;
  assign bus.imem_addr_o = pc_q;
  assign bus.id_valid_o  = !rst_i && head_valid;
  assign bus.id_instr_o  = rst_i ? NOP_INSTR : head_instr;
  assign bus.id_pc_o     = rst_i ? 32'h0 : head_pc;

  // A response with nothing to kill and no slot waiting for it is a memory
  // protocol violation; it is ignored by the datapath.
  a_no_orphan_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
    !(bus.imem_rvalid_i && (kill_cnt == '0) && (unfilled == '0)));

  a_kill_bounded: assert property (@(posedge clk_i) disable iff (rst_i)
    ({1'b0, kill_cnt} <= DEPTH_W));

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;
  import instr_fetch_unit_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- memory model / scoreboard state ----------------
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t    mem_q[$];
  logic [31:0] exp_q[$];
  int lat    = 1;
  int cyc    = 0;
  int grants = 0;
  int checks = 0;
  int errors = 0;

  logic        s_req, s_valid;
  logic [31:0] s_addr, s_instr, s_pc;

  function automatic logic [31:0] data_of(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock cycle: inputs are set by the caller at the negedge; the memory
  // model drives its response, outputs are sampled, then the edge happens.
  task automatic cycle();
    logic [31:0] e;
    if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
      bus.imem_rvalid_i = 1'b1;
      bus.imem_rdata_i  = data_of(mem_q[0].addr);
    end else begin
      bus.imem_rvalid_i = 1'b0;
      bus.imem_rdata_i  = 32'h0;
    end
    #1;
    s_req   = bus.imem_req_o;
    s_addr  = bus.imem_addr_o;
    s_valid = bus.id_valid_o;
    s_instr = bus.id_instr_o;
    s_pc    = bus.id_pc_o;
    if (s_valid && bus.id_ready_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_handshake: got pc %h expected no transfer (cycle %0d)", s_pc, cyc);
      end else begin
        e = exp_q.pop_front();
        check32("hs_pc", s_pc, e);
        check32("hs_instr", s_instr, data_of(e));
      end
    end
    @(posedge clk);
    if (!rst) begin
      if (bus.imem_rvalid_i) mem_q.delete(0);
      if (s_req && bus.imem_gnt_i) begin
        mem_q.push_back('{s_addr, cyc + lat});
        grants++;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // Reset for two cycles; memory is reset alongside the DUT.
  task automatic do_reset();
    rst = 1'b1;
    mem_q.delete();
    bus.imem_gnt_i    = 1'b0;
    bus.id_ready_i    = 1'b0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check32("rst_req", {31'h0, s_req}, 32'h0);
      check32("rst_valid", {31'h0, s_valid}, 32'h0);
      check32("rst_instr", s_instr, NOP_INSTR);
      check32("rst_pc", s_pc, 32'h0);
    end
    rst = 1'b0;
    cyc = 0;
    grants = 0;
  endtask

  // Accept instructions while expectations remain, within a cycle budget.
  task automatic drain(input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      bus.id_ready_i = 1'b1;
      cycle();
      n++;
    end
    bus.id_ready_i = 1'b0;
    check32("drain_left", exp_q.size(), 32'h0);
    exp_q.delete();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic        gnt;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs[13];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.imem_gnt_i    = 1'b0;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = 32'h0;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.id_ready_i    = 1'b0;

    // Streaming from reset with 1-cycle memory, then a stall that exhausts
    // credit, then resume (credit returns the cycle after a pop).
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h04, 1'b0, 32'h00};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
    vecs[3]  = '{1'b1, 1'b1, 1'b1, 32'h0c, 1'b1, 32'h04};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h0c};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h10};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h1c, 1'b1, 32'h14};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h20, 1'b1, 32'h18};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 32'h24, 1'b1, 32'h18};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 32'h28, 1'b1, 32'h18};
    vecs[11] = '{1'b1, 1'b1, 1'b0, 32'h28, 1'b1, 32'h18};
    vecs[12] = '{1'b1, 1'b1, 1'b1, 32'h28, 1'b1, 32'h1c};

    @(negedge clk);

    // ---- table test ----
    lat = 1;
    do_reset();
    for (int a = 0; a < 8; a++) exp_q.push_back(32'(a * 4));
    for (int i = 0; i < 13; i++) begin
      bus.imem_gnt_i = vecs[i].gnt;
      bus.id_ready_i = vecs[i].ready;
      cycle();
      check32("tbl_req", {31'h0, s_req}, {31'h0, vecs[i].exp_req});
      check32("tbl_addr", s_addr, vecs[i].exp_addr);
      check32("tbl_valid", {31'h0, s_valid}, {31'h0, vecs[i].exp_valid});
      check32("tbl_pc", s_pc, vecs[i].exp_pc);
    end
    bus.id_ready_i = 1'b0;
    check32("tbl_sb_left", exp_q.size(), 32'h0);
    exp_q.delete();

    // ---- stall from reset: 4 grants then no request, head held ----
    lat = 1;
    do_reset();
    bus.imem_gnt_i = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (k >= 4) check32("stall_req", {31'h0, s_req}, 32'h0);
      if (k >= 2) begin
        check32("stall_pc", s_pc, 32'h0);
        check32("stall_instr", s_instr, data_of(32'h0));
      end
    end
    check32("stall_grants", grants, 32'd4);
    for (int a = 0; a < 5; a++) exp_q.push_back(32'(a * 4));
    drain(30);

    // ---- 3-cycle memory, 2 outstanding, redirect to 0x100 ----
    lat = 3;
    do_reset();
    bus.imem_gnt_i = 1'b1;
    repeat (2) cycle();
    bus.imem_gnt_i    = 1'b0;
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0100;
    cycle();
    check32("redir_req", {31'h0, s_req}, 32'h0);
    bus.redirect_i = 1'b0;
    bus.imem_gnt_i = 1'b1;
    cycle();
    check32("redir_addr", s_addr, 32'h0000_0100);
    check32("redir_valid", {31'h0, s_valid}, 32'h0);
    exp_q.push_back(32'h0000_0100);
    drain(20);

    // ---- redirect coincident with rvalid, 2 unfilled: one kill left ----
    lat = 2;
    do_reset();
    bus.imem_gnt_i = 1'b1;
    repeat (2) cycle();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0200;
    cycle();
    check32("coinc_req", {31'h0, s_req}, 32'h0);
    bus.redirect_i = 1'b0;
    cycle();
    check32("coinc_addr", s_addr, 32'h0000_0200);
    exp_q.push_back(32'h0000_0200);
    drain(20);

    // ---- unaligned redirect target is word-aligned ----
    lat = 1;
    do_reset();
    bus.imem_gnt_i = 1'b1;
    repeat (3) cycle();
    bus.redirect_i    = 1'b1;
    bus.redirect_pc_i = 32'h0000_0102;
    cycle();
    check32("align_req", {31'h0, s_req}, 32'h0);
    bus.redirect_i = 1'b0;
    cycle();
    check32("align_addr", s_addr, 32'h0000_0100);
    check32("align_valid", {31'h0, s_valid}, 32'h0);
    exp_q.push_back(32'h0000_0100);
    drain(20);

    // ---- withheld grant keeps address; reset with 2 outstanding ----
    lat = 3;
    do_reset();
    bus.imem_gnt_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      check32("hold_req", {31'h0, s_req}, 32'h1);
      check32("hold_addr", s_addr, 32'h0);
    end
    bus.imem_gnt_i = 1'b1;
    cycle();
    cycle();
    check32("hold_addr2", s_addr, 32'h4);
    bus.imem_gnt_i = 1'b0;
    do_reset();
    cycle();
    check32("post_rst_addr", s_addr, 32'h0);
    check32("post_rst_req", {31'h0, s_req}, 32'h1);
    check32("post_rst_valid", {31'h0, s_valid}, 32'h0);
    check32("post_rst_instr", s_instr, NOP_INSTR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
